// File: rtl/ram_pkg.sv
// ram_pkg: shared line geometry, FSM encoding and line-index helper for the RAM responder.
package ram_pkg;
  localparam int LINE_BYTES = 64;
  localparam int OFFSET_BITS = 6;
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, RESPOND = 2'b10} state_e;
  function automatic logic [63:0] line_idx(input logic [63:0] addr);
    return addr >> OFFSET_BITS;
  endfunction
endpackage

// File: rtl/ram_line_array.sv
// ram_line_array: single-port 1RW line store with registered read; reads hold their value across writes.
module ram_line_array #(
  parameter int LINE_W = 512,
  parameter int DEPTH = 256,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic [LINE_W-1:0] wdata_i,
  output logic [LINE_W-1:0] rdata_o
);
  logic [LINE_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      else rdata_o <= mem_q[addr_i];
    end
  end
endmodule

// File: rtl/ram_responder.sv
// ram_responder: fixed-latency line RAM that answers cache fill and write-back requests.
module ram_responder
  import ram_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 512,
  parameter int DEPTH_LINES = 256,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ram_req,
  input  logic              ram_we,
  input  logic [ADDR_W-1:0] ram_address,
  input  logic [LINE_W-1:0] ram_write_data,
  output logic [LINE_W-1:0] ram_read_data,
  output logic              ram_ready,
  output logic              ram_err,
  output logic              busy
);
  localparam int IDX_W = $clog2(DEPTH_LINES);
  localparam int CNT_W = LATENCY > 1 ? $clog2(LATENCY) : 1;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, in_idx, arr_addr;
  logic [LINE_W-1:0] wdata_q, arr_rdata;
  logic we_q, oor_q, in_oor, nxt_we, nxt_oor, rd_go, wr_go;
  logic ready_q, err_q, busy_q, zero_q;
  always_comb begin
    in_idx = IDX_W'(line_idx(64'(ram_address)));
    in_oor = 64'(ram_address) >= 64'(DEPTH_LINES) * 64'(LINE_BYTES);
    nxt_we = state_q == IDLE ? ram_we : we_q;
    nxt_oor = state_q == IDLE ? in_oor : oor_q;
    arr_addr = state_q == IDLE ? in_idx : idx_q;
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (ram_req) begin
        state_d = LATENCY == 1 ? RESPOND : BUSY;
        cnt_d = CNT_W'(LATENCY - 1);
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        state_d = cnt_q == CNT_W'(1) ? RESPOND : BUSY;
      end
      default: state_d = IDLE;
    endcase
    // read is launched on the edge entering RESPOND so data lands with ram_ready
    rd_go = rst && state_d == RESPOND && !nxt_we && !nxt_oor;
    wr_go = rst && state_q == RESPOND && we_q && !oor_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ready_q <= 1'b0;
      err_q <= 1'b0;
      busy_q <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ready_q <= state_d == RESPOND;
      err_q <= state_d == RESPOND && nxt_oor;
      busy_q <= state_d != IDLE;
      if (state_d == RESPOND && !nxt_we) zero_q <= nxt_oor;
    end
  end
  always_ff @(posedge clk) begin
    if (state_q == IDLE && ram_req) begin
      we_q <= ram_we;
      idx_q <= in_idx;
      wdata_q <= ram_write_data;
      oor_q <= in_oor;
    end
  end
  ram_line_array #(.LINE_W(LINE_W), .DEPTH(DEPTH_LINES)) u_array (
    .clk(clk),
    .en_i(rd_go || wr_go),
    .we_i(wr_go),
    .addr_i(arr_addr),
    .wdata_i(wdata_q),
    .rdata_o(arr_rdata)
  );
  assign ram_read_data = zero_q ? '0 : arr_rdata;
  assign ram_ready = ready_q;
  assign ram_err = err_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder: transaction-level model plus directed vectors for the RAM responder.
module tb_ram_responder;
  localparam int LAT = 4;
  localparam int DEPTH = 256;
  localparam logic [511:0] D0 = {16{32'h0000_00D0}};
  localparam logic [511:0] DA = {16{32'hA5A5_0001}};
  localparam logic [511:0] D7 = {16{32'h7777_0007}};
  localparam logic [511:0] D2 = {16{32'h2222_0002}};
  localparam logic [511:0] P4 = {16{32'h4444_0004}};
  localparam logic [511:0] DZ = {16{32'hDEAD_BEEF}};
  localparam logic [511:0] DW = {16{32'hBAD0_BAD0}};
  localparam logic [511:0] DQ = {16{32'h1111_0001}};
  logic clk = 0, rst = 0;
  logic req = 0, we_s = 0;
  logic [31:0] addr_s = '0;
  logic [511:0] wd_s = '0;
  logic [511:0] ram_read_data;
  logic ram_ready, ram_err, busy;
  logic req1 = 0, we1 = 0;
  logic [31:0] addr1 = '0;
  logic [511:0] wd1 = '0, rd1;
  logic rdy1, err1, busy1;
  int checks = 0, errors = 0, cyc = 0;
  int lat, rc, rc_prev, t0;
  logic r_err;
  logic [511:0] r_rd;
  bit chk_en = 0;
  always #5 clk = ~clk;
  ram_responder #(.ADDR_W(32), .LINE_W(512), .DEPTH_LINES(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .ram_req(req), .ram_we(we_s), .ram_address(addr_s),
    .ram_write_data(wd_s), .ram_read_data(ram_read_data), .ram_ready(ram_ready),
    .ram_err(ram_err), .busy(busy)
  );
  ram_responder #(.ADDR_W(32), .LINE_W(512), .DEPTH_LINES(DEPTH), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .ram_req(req1), .ram_we(we1), .ram_address(addr1),
    .ram_write_data(wd1), .ram_read_data(rd1), .ram_ready(rdy1),
    .ram_err(err1), .busy(busy1)
  );
  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask
  // Transaction model: a request seen while idle completes LAT cycles later.
  logic [511:0] mem [int];
  bit act = 0, m_we, m_oor, e_busy, e_rdy, e_err, e_known = 1;
  int done_c, m_idx;
  logic [511:0] m_wd, e_rd = '0;
  always @(posedge clk) begin
    if (!rst) begin
      act = 0; e_busy = 0; e_rdy = 0; e_err = 0; e_rd = '0; e_known = 1;
    end else begin
      if (act && cyc == done_c) begin
        if (m_we && !m_oor) mem[m_idx] = m_wd;
        act = 0;
      end else if (!act && req) begin
        act = 1; done_c = cyc + LAT; m_we = we_s; m_wd = wd_s;
        m_oor = addr_s >= 32'(DEPTH * 64);
        m_idx = int'(addr_s >> 6);
      end
      e_busy = act;
      e_rdy = act && (cyc + 1 == done_c);
      e_err = e_rdy && m_oor;
      if (e_rdy && !m_we) begin
        if (m_oor) begin e_rd = '0; e_known = 1; end
        else if (mem.exists(m_idx)) begin e_rd = mem[m_idx]; e_known = 1; end
        else e_known = 0;
      end
    end
    cyc++;
  end
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, e_busy);
      chk("ready", ram_ready, e_rdy);
      chk("err", ram_err, e_err);
      if (e_known) chk("rdata", ram_read_data, e_rd);
    end
  end
  task automatic txn(input logic w, input logic [31:0] a, input logic [511:0] d, input bit hold, input bit drop);
    req = 1; we_s = w; addr_s = a; wd_s = d; t0 = cyc; lat = -1;
    if (drop) begin @(posedge clk); #1; req = 0; end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ram_ready) begin
        lat = cyc - t0; rc = cyc; r_err = ram_err; r_rd = ram_read_data;
        break;
      end
    end
    chk("latency", 512'(lat), 512'(LAT));
    @(posedge clk); #1;
    if (!hold) req = 0;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1;
    chk("reset_ready", ram_ready, 0);
    chk("reset_rdata", ram_read_data, 0);
    rst = 1;
    txn(1, 32'h0000_0000, D0, 0, 0);
    txn(1, 32'h0000_0040, DA, 0, 0);
    txn(0, 32'h0000_0040, '0, 0, 0);
    chk("rd40_data", r_rd, {16{32'hA5A5_0001}});
    chk("rd40_err", r_err, 0);
    txn(1, 32'h0000_01C0, D7, 0, 0);
    txn(1, 32'h0000_0080, D2, 1, 0);
    rc_prev = rc;
    txn(0, 32'h0000_01C0, '0, 0, 0);
    chk("b2b_gap", 512'(rc - rc_prev), 512'(5));
    chk("b2b_fill", r_rd, D7);
    txn(0, 32'h0000_0080, '0, 0, 0);
    chk("wb80_data", r_rd, D2);
    txn(1, 32'h0000_0100, P4, 0, 0);
    txn(0, 32'h0000_0100, '0, 0, 0);
    req = 1; we_s = 1; addr_s = 32'h100; wd_s = DZ;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0; req = 0;
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("abort_ready", ram_ready, 0);
    chk("abort_busy", busy, 0);
    chk("abort_err", ram_err, 0);
    chk("abort_rdata", ram_read_data, 0);
    r_err = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ram_ready) r_err = 1;
    end
    chk("abort_no_ready", r_err, 0);
    @(posedge clk); #1;
    txn(0, 32'h0000_0100, '0, 0, 0);
    chk("line4_kept", r_rd, P4);
    txn(0, 32'h0000_4000, '0, 0, 0);
    chk("oor_err", r_err, 1);
    chk("oor_data", r_rd, 0);
    txn(1, 32'h0000_4000, DW, 0, 0);
    chk("oor_wr_err", r_err, 1);
    txn(0, 32'h0000_0000, '0, 0, 0);
    chk("line0_kept", r_rd, D0);
    txn(0, 32'h0000_0040, '0, 0, 0);
    chk("line1_kept", r_rd, DA);
    txn(0, 32'h0000_0080, '0, 0, 1);
    chk("drop_data", r_rd, D2);
    req1 = 1; we1 = 1; addr1 = 32'h0; wd1 = DQ;
    @(negedge clk);
    chk("l1_w_c0", rdy1, 0);
    @(negedge clk);
    chk("l1_w_c1", rdy1, 1);
    @(posedge clk); #1;
    we1 = 0; addr1 = 32'h3F;
    @(negedge clk);
    chk("l1_r_c0", rdy1, 0);
    @(negedge clk);
    chk("l1_r_c1", rdy1, 1);
    chk("l1_r_data", rd1, DQ);
    chk("l1_r_err", err1, 0);
    @(posedge clk); #1;
    req1 = 0;
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_responder.md
# ram_responder

Memory-side responder for the cache controller's RAM request interface. It accepts line-sized read (fill) and write (write-back) requests on `ram_req`/`ram_address` and completes each one after a fixed, programmable latency by pulsing `ram_ready`. Line storage is held in an internal array. The block sits below the cache controller and serves as both the simulation main memory and the synthesizable on-chip backing store.

## Interface
- `ADDR_W`, 32, byte-address width.
- `LINE_W`, 512, line width in bits (64-byte lines).
- `DEPTH_LINES`, 256, number of lines stored; must be a power of two.
- `LATENCY`, 4, cycles from request acceptance to `ram_ready`; legal range is ≥1.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `ram_req`  in  1  request valid; held high with stable fields until `ram_ready`.
- `ram_we`  in  1  1 = write-back, 0 = line fill (read).
- `ram_address`  in  ADDR_W  byte address; bits [5:0] are ignored.
- `ram_write_data`  in  LINE_W  write-back line.
- `ram_read_data`  out  LINE_W  fill line; valid from the `ram_ready` cycle until the next acceptance.
- `ram_ready`  out  1  one-cycle completion pulse.
- `ram_err`  out  1  pulses with `ram_ready` when the address is out of range.
- `busy`  out  1  high from acceptance through the `ram_ready` cycle.

## Operation
- State machine with three states: IDLE → BUSY → RESPOND → IDLE.
- IDLE
  - If `ram_req`=1, accept the request: latch `ram_we`, line index = `ram_address[6 +: log2(DEPTH_LINES)]`, write data, and range flag.
  - Load the counter with `LATENCY-1`.
  - Go to RESPOND if `LATENCY`=1, otherwise go to BUSY.
- BUSY
  - Decrement the counter each cycle.
  - At 0, go to RESPOND.
  - `ram_req`, `ram_address` and `ram_we` are ignored while in BUSY.
- RESPOND
  - Drive `ram_ready`=1 for exactly one cycle, then return to IDLE.
  - Read: `ram_read_data` = array[index], registered so it is valid in this cycle.
  - Write: the array is updated at the end of this cycle, and `ram_read_data` is unchanged.
- Out-of-range address (`ram_address >= DEPTH_LINES*64`):
  - `ram_err`=1 together with `ram_ready`.
  - Read returns all zeros; the write is dropped.
- Back-to-back: if `ram_req` is still high in the IDLE cycle after RESPOND (write-back immediately followed by fill), it is accepted as a new request. There are no idle gaps beyond that one IDLE cycle.
- Dropping `ram_req` mid-transaction does not abort it; it completes and still pulses `ram_ready`.
- The requester sampling the pulse is responsible for deasserting `ram_req`; a request still high after RESPOND is always treated as new.

## Timing
- Acceptance edge = end of cycle 0 (IDLE with `ram_req`=1).
- `ram_ready` is high in cycle `LATENCY`. Transaction-to-transaction period = `LATENCY`+1 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset (`rst`=0 at an edge), including mid-transaction:
  - State → IDLE, the in-flight request is discarded.
  - `ram_ready`=0, `ram_err`=0, `busy`=0, `ram_read_data`=0, counter=0.
  - The array contents are not reset; write data takes effect only in RESPOND.
- Counter width is `$clog2(LATENCY)`, minimum 1 bit. It never wraps because it is reloaded only in IDLE.

## Structure
- Shared package `ram_pkg` holds:
  - `LINE_BYTES`=64, `OFFSET_BITS`=6.
  - The state encoding IDLE=2'b00, BUSY=2'b01, RESPOND=2'b10.
  - A line-index extraction function.
- Sub-module `ram_line_array`: single-port synchronous 1RW array of `DEPTH_LINES`×`LINE_W`, with registered read and write-enable. No reset.
- The top level holds the FSM, counter, request latches and range check.

## Test plan
- Write addr 0x0000_0040 data {16{32'hA5A5_0001}}, then read the same address → second `ram_ready` is 4 cycles after acceptance, `ram_read_data` equals the written data, `ram_err`=0.
- Write-back to 0x80 followed by fill from 0x1C0, with `ram_req` held high throughout (address switched on `ram_ready`) → two pulses 5 cycles apart, 0x80 updated, fill returns array[7].
- Read 0x0000_4000 with DEPTH_LINES=256 → `ram_err`=1 and `ram_ready`=1 in cycle 4, data=0; a following write to 0x4000 leaves all lines unchanged.
- `rst`=0 in cycle 2 of a write to 0x100 → no `ram_ready`, line 4 unchanged, all outputs 0 on the next cycle.
- `LATENCY`=1 build: read 0x3F (offset ignored, line 0) → `ram_ready` in cycle 1. Drop `ram_req` after acceptance in a `LATENCY`=4 build → `ram_ready` still arrives in cycle 4.
